// File: rtl/pixel_unpacker.sv
// pixel_unpacker
//   Pulls 16-bit words out of the pixel FIFO (clk_20 domain) using credit
//   tracking so the FIFO is never over-popped, then repacks every three words
//   into two 24-bit GRB pixels presented on a valid/ready handshake.
//
// Ports
//   clk              pixel clock (clk_20)
//   reset            synchronous, active-high
//   fifo_count       FIFO occupancy, FIFO_ADDR_WIDTH+1 bits
//   fifo_rd          registered FIFO read strobe, one word per high cycle
//   fifo_data        FIFO read data
//   fifo_data_valid  fifo_data valid this cycle (FIFO_LATENCY after fifo_rd)
//   flush            drop partial pixel state and realign to word phase 0
//   pixel_data       {G,R,B}, G in [23:16]
//   pixel_valid      pixel_data valid
//   pixel_ready      consumer accepts when pixel_valid && pixel_ready
//   rd_err           sticky: data returned with no read in flight
module pixel_unpacker #(
  parameter int FIFO_ADDR_WIDTH = 12,
  parameter int FIFO_LATENCY    = 2,
  parameter int WORD_BUF_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FIFO_ADDR_WIDTH:0] fifo_count,
  output logic                     fifo_rd,
  input  logic [15:0]              fifo_data,
  input  logic                     fifo_data_valid,
  input  logic                     flush,
  output logic [23:0]              pixel_data,
  output logic                     pixel_valid,
  input  logic                     pixel_ready,
  output logic                     rd_err
);

  localparam int PTR_W = (WORD_BUF_DEPTH > 1) ? $clog2(WORD_BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {PH0, PH2} phase_t;

  logic [15:0]      word_buf [WORD_BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_n1;
  logic [CNT_W-1:0] buf_used, avail;
  logic [2:0]       inflight, inflight_next, drop_cnt;
  logic [7:0]       res, res_next;
  phase_t           phase, phase_next;

  logic        accept_word, rd_err_set, issue_next, can_form, load;
  logic [1:0]  pop;
  logic [15:0] head0, head1;
  logic [23:0] formed;

  assign rd_err_set  = fifo_data_valid && (inflight == '0);
  assign accept_word = fifo_data_valid && (inflight != '0) && (drop_cnt == '0) && !flush;

  // The strobe currently on the wire has not reached inflight yet, so it is
  // added in explicitly; a return with nothing in flight is an error, not a credit.
  assign inflight_next = inflight + {2'b00, fifo_rd} - {2'b00, (fifo_data_valid && (inflight != '0))};

  assign issue_next = !flush && (drop_cnt == '0)
                      && (int'(fifo_count) > int'(inflight) + int'(fifo_rd))
                      && (int'(buf_used) + int'(inflight) + int'(fifo_rd) < WORD_BUF_DEPTH);

  // The word arriving this cycle is bypassed straight into the unpacker so the
  // first pixel does not wait an extra cycle for the buffer write.
  assign avail     = buf_used + CNT_W'(accept_word);
  assign rd_ptr_n1 = rd_ptr + PTR_W'(1);
  assign head0     = (buf_used != '0) ? word_buf[rd_ptr] : fifo_data;
  assign head1     = (buf_used > CNT_W'(1)) ? word_buf[rd_ptr_n1] : fifo_data;

  // Unpack phase: PH0 takes two words and keeps the low byte of the second as
  // residue; PH2 combines that residue with one more word.
  always_comb begin
    can_form   = 1'b0;
    formed     = '0;
    pop        = 2'd0;
    res_next   = res;
    phase_next = phase;
    case (phase)
      PH0: begin
        if (avail >= CNT_W'(2)) begin
          can_form   = 1'b1;
          formed     = {head0, head1[15:8]};
          pop        = 2'd2;
          res_next   = head1[7:0];
          phase_next = PH2;
        end
      end
      PH2: begin
        if (avail >= CNT_W'(1)) begin
          can_form   = 1'b1;
          formed     = {res, head0};
          pop        = 2'd1;
          phase_next = PH0;
        end
      end
      default: phase_next = PH0;
    endcase
  end

  assign load = can_form && (!pixel_valid || pixel_ready);

  // Word storage carries no reset; occupancy is tracked by buf_used alone.
  always_ff @(posedge clk) begin
    if (accept_word) begin
      word_buf[wr_ptr] <= fifo_data;
    end
  end

  // Control state. Flush clears everything and arms drop_cnt with all reads
  // still outstanding (including a strobe issued in the flush cycle), so those
  // words are swallowed on return and cannot misalign the new phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_rd     <= 1'b0;
      inflight    <= '0;
      drop_cnt    <= '0;
      rd_err      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      buf_used    <= '0;
      res         <= '0;
      phase       <= PH0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
    end else begin
      fifo_rd  <= issue_next;
      inflight <= inflight_next;
      if (rd_err_set) begin
        rd_err <= 1'b1;
      end
      if (flush) begin
        drop_cnt    <= inflight_next;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        buf_used    <= '0;
        res         <= '0;
        phase       <= PH0;
        pixel_valid <= 1'b0;
      end else begin
        if (fifo_data_valid && (inflight != '0) && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - 3'd1;
        end
        if (accept_word) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        buf_used <= buf_used + CNT_W'(accept_word) - (load ? CNT_W'(pop) : CNT_W'(0));
        if (load) begin
          rd_ptr      <= rd_ptr + PTR_W'(pop);
          res         <= res_next;
          phase       <= phase_next;
          pixel_data  <= formed;
          pixel_valid <= 1'b1;
        end else if (pixel_ready) begin
          pixel_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_unpacker.sv
// tb_pixel_unpacker
//   Directed bench for pixel_unpacker. A small FIFO model returns words
//   FIFO_LATENCY cycles after each fifo_rd; each task drives one scenario and
//   compares outputs against hand-computed or word-derived pixels.
module tb_pixel_unpacker;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic [12:0] fifo_count;
  logic        fifo_rd;
  logic [15:0] fifo_data;
  logic        fifo_data_valid;
  logic        flush;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        rd_err;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:1023];
  int  loaded = 0;
  int  popped = 0;
  int  cyc = 0;
  bit  inject = 0;
  logic r1 = 0;
  logic r2 = 0;

  pixel_unpacker #(
    .FIFO_ADDR_WIDTH(12),
    .FIFO_LATENCY(LAT),
    .WORD_BUF_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fifo_count(fifo_count),
    .fifo_rd(fifo_rd),
    .fifo_data(fifo_data),
    .fifo_data_valid(fifo_data_valid),
    .flush(flush),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .rd_err(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: count covers words not yet returned; data appears two cycles
  // after the strobe; an injected word appears with no read behind it.
  initial begin
    fifo_data_valid = 1'b0;
    fifo_data = '0;
    fifo_count = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      fifo_count = 13'(loaded - popped);
      if (r2) begin
        fifo_data_valid = 1'b1;
        fifo_data = mem[popped];
        popped++;
      end else if (inject) begin
        fifo_data_valid = 1'b1;
        fifo_data = 16'hDEAD;
        inject = 0;
      end else begin
        fifo_data_valid = 1'b0;
      end
      @(negedge clk);
      r2 = r1;
      r1 = fifo_rd;
    end
  end

  function automatic logic [23:0] exp_pix(input int base, input int k);
    int w;
    w = base + (k / 2) * 3;
    if (k % 2 == 0) return {mem[w], mem[w+1][15:8]};
    return {mem[w+1][7:0], mem[w+2]};
  endfunction

  task automatic load_word(input logic [15:0] w);
    mem[loaded] = w;
    loaded++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    flush = 1'b0;
    pixel_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (fifo_rd !== 1'b0) begin failures++; $display("[TB] FAIL reset_fifo_rd got %b expected 0", fifo_rd); end
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_pixel_valid got %b expected 0", pixel_valid); end
    checks++; if (pixel_data !== 24'h0) begin failures++; $display("[TB] FAIL reset_pixel_data got %h expected 000000", pixel_data); end
    checks++; if (rd_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_err got %b expected 0", rd_err); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [23:0] e [2];
    int got, rds, first_rd, first_pv;
    e[0] = 24'h112233;
    e[1] = 24'h445566;
    got = 0; rds = 0; first_rd = -1; first_pv = -1;
    pixel_ready = 1'b1;
    load_word(16'h1122); load_word(16'h3344); load_word(16'h5566);
    repeat (30) begin
      @(negedge clk);
      if (fifo_rd) begin rds++; if (first_rd < 0) first_rd = cyc; end
      if (pixel_valid) begin
        if (first_pv < 0) first_pv = cyc;
        if (got < 2) begin
          checks++;
          if (pixel_data !== e[got]) begin failures++; $display("[TB] FAIL basic_pixel%0d got %h expected %h", got, pixel_data, e[got]); end
        end
        got++;
      end
    end
    checks++; if (got != 2) begin failures++; $display("[TB] FAIL basic_pixel_count got %0d expected 2", got); end
    checks++; if (rds != 3) begin failures++; $display("[TB] FAIL basic_rd_count got %0d expected 3", rds); end
    checks++; if (first_pv - first_rd != LAT + 2) begin failures++; $display("[TB] FAIL basic_latency got %0d expected %0d", first_pv - first_rd, LAT + 2); end
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_valid_low got %b expected 0", pixel_valid); end
  endtask

  task automatic test_stream;
    int base, got, rds, pop0, out, max_out, n;
    base = loaded; got = 0; rds = 0; pop0 = popped; max_out = 0; n = 0;
    pixel_ready = 1'b1;
    for (int i = 0; i < 300; i++) load_word(16'(i * 40503 + 17));
    while (got < 200 && n < 2000) begin
      @(negedge clk);
      n++;
      if (fifo_rd) rds++;
      out = rds - (popped - pop0);
      if (out > max_out) max_out = out;
      if (pixel_valid) begin
        checks++;
        if (pixel_data !== exp_pix(base, got)) begin failures++; $display("[TB] FAIL stream_pixel%0d got %h expected %h", got, pixel_data, exp_pix(base, got)); end
        got++;
      end
    end
    checks++; if (got != 200) begin failures++; $display("[TB] FAIL stream_pixel_count got %0d expected 200", got); end
    checks++; if (max_out > LAT) begin failures++; $display("[TB] FAIL stream_inflight got %0d expected <= %0d", max_out, LAT); end
    repeat (3) @(negedge clk);
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_valid_low got %b expected 0", pixel_valid); end
  endtask

  task automatic test_back_to_back;
    int base, got, n, stall_rd;
    logic [23:0] held;
    bit unstable;
    base = loaded; got = 0; n = 0; stall_rd = 0; unstable = 0; held = '0;
    pixel_ready = 1'b1;
    for (int i = 0; i < 30; i++) load_word(16'(16'hA000 + i * 16'h0111));
    while (got < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (pixel_valid && pixel_ready) begin
        checks++;
        if (pixel_data !== exp_pix(base, got)) begin failures++; $display("[TB] FAIL bp_pixel%0d got %h expected %h", got, pixel_data, exp_pix(base, got)); end
        got++;
      end
    end
    pixel_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) held = pixel_data;
      if (!pixel_valid || pixel_data !== held) unstable = 1;
      if (i >= 10 && fifo_rd) stall_rd++;
    end
    checks++; if (unstable) begin failures++; $display("[TB] FAIL bp_hold got %h expected stable %h", pixel_data, held); end
    checks++; if (stall_rd != 0) begin failures++; $display("[TB] FAIL bp_rd_stop got %0d expected 0", stall_rd); end
    pixel_ready = 1'b1;
    n = 0;
    while (got < 20 && n < 300) begin
      @(negedge clk);
      n++;
      if (pixel_valid && pixel_ready) begin
        checks++;
        if (pixel_data !== exp_pix(base, got)) begin failures++; $display("[TB] FAIL bp_pixel%0d got %h expected %h", got, pixel_data, exp_pix(base, got)); end
        got++;
      end
    end
    checks++; if (got != 20) begin failures++; $display("[TB] FAIL bp_pixel_count got %0d expected 20", got); end
    repeat (3) @(negedge clk);
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_valid_low got %b expected 0", pixel_valid); end
  endtask

  task automatic test_flush;
    logic [23:0] e [2];
    int rds, n, got, late_rd, late_pv;
    e[0] = 24'hAABBCC;
    e[1] = 24'hDDEEFF;
    rds = 0; n = 0; got = 0; late_rd = 0; late_pv = 0;
    pixel_ready = 1'b0;
    load_word(16'h0101); load_word(16'h0202); load_word(16'h0303); load_word(16'h0404);
    while (rds < 4 && n < 50) begin
      @(negedge clk);
      n++;
      if (fifo_rd) rds++;
    end
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid_low got %b expected 0", pixel_valid); end
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (fifo_rd) late_rd++;
      if (pixel_valid) late_pv++;
    end
    checks++; if (popped != loaded) begin failures++; $display("[TB] FAIL flush_drain got %0d expected %0d", popped, loaded); end
    checks++; if (late_rd != 0) begin failures++; $display("[TB] FAIL flush_no_rd got %0d expected 0", late_rd); end
    checks++; if (late_pv != 0) begin failures++; $display("[TB] FAIL flush_no_pixel got %0d expected 0", late_pv); end
    pixel_ready = 1'b1;
    load_word(16'hAABB); load_word(16'hCCDD); load_word(16'hEEFF);
    repeat (30) begin
      @(negedge clk);
      if (pixel_valid) begin
        if (got < 2) begin
          checks++;
          if (pixel_data !== e[got]) begin failures++; $display("[TB] FAIL flush_pixel%0d got %h expected %h", got, pixel_data, e[got]); end
        end
        got++;
      end
    end
    checks++; if (got != 2) begin failures++; $display("[TB] FAIL flush_pixel_count got %0d expected 2", got); end
  endtask

  task automatic test_rd_err;
    logic [23:0] e [2];
    int got;
    e[0] = 24'h0A0B0C;
    e[1] = 24'h0D0E0F;
    got = 0;
    pixel_ready = 1'b1;
    inject = 1;
    repeat (3) @(negedge clk);
    checks++; if (rd_err !== 1'b1) begin failures++; $display("[TB] FAIL rd_err_set got %b expected 1", rd_err); end
    load_word(16'h0A0B); load_word(16'h0C0D); load_word(16'h0E0F);
    repeat (30) begin
      @(negedge clk);
      if (pixel_valid) begin
        if (got < 2) begin
          checks++;
          if (pixel_data !== e[got]) begin failures++; $display("[TB] FAIL rd_err_pixel%0d got %h expected %h", got, pixel_data, e[got]); end
        end
        got++;
      end
    end
    checks++; if (got != 2) begin failures++; $display("[TB] FAIL rd_err_pixel_count got %0d expected 2", got); end
    checks++; if (rd_err !== 1'b1) begin failures++; $display("[TB] FAIL rd_err_sticky got %b expected 1", rd_err); end
  endtask

  task automatic test_trailing;
    int rds, pv, got;
    rds = 0; pv = 0; got = 0;
    pixel_ready = 1'b1;
    load_word(16'h1357);
    repeat (15) begin
      @(negedge clk);
      if (fifo_rd) rds++;
      if (pixel_valid) pv++;
    end
    checks++; if (rds != 1) begin failures++; $display("[TB] FAIL trail_rd_count got %0d expected 1", rds); end
    checks++; if (pv != 0) begin failures++; $display("[TB] FAIL trail_no_pixel got %0d expected 0", pv); end
    load_word(16'h2468);
    repeat (20) begin
      @(negedge clk);
      if (pixel_valid) begin
        if (got == 0) begin
          checks++;
          if (pixel_data !== 24'h135724) begin failures++; $display("[TB] FAIL trail_pixel got %h expected 135724", pixel_data); end
        end
        got++;
      end
    end
    checks++; if (got != 1) begin failures++; $display("[TB] FAIL trail_pixel_count got %0d expected 1", got); end
  endtask

  task automatic test_reset_mid;
    int got;
    got = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rd_err !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_rd_err got %b expected 0", rd_err); end
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_valid got %b expected 0", pixel_valid); end
    reset = 1'b0;
    load_word(16'h9ABC); load_word(16'hDEF0);
    repeat (20) begin
      @(negedge clk);
      if (pixel_valid) begin
        if (got == 0) begin
          checks++;
          if (pixel_data !== 24'h9ABCDE) begin failures++; $display("[TB] FAIL mid_reset_pixel got %h expected 9abcde", pixel_data); end
        end
        got++;
      end
    end
    checks++; if (got != 1) begin failures++; $display("[TB] FAIL mid_reset_pixel_count got %0d expected 1", got); end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    pixel_ready = 1'b0;
    test_reset();
    test_basic();
    test_stream();
    test_back_to_back();
    test_flush();
    test_rd_err();
    test_trailing();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
